data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder side of the pipeline's MEM-stage data-memory interface. It accepts the load/store requests that the EX/MEM segment presents and returns acknowledgment and read data under a req/ready handshake. Stores complete in a single cycle through a one-entry write buffer; loads take a configurable number of wait states. The core uses `req & ~ready` as its MEM-stage stall condition.

## Interface
- `DEPTH`, 1024: number of 32-bit words; word-addressed, matching the core's PC+1 addressing.
- `AW`, 10: address bits used to index the array; equals log2(DEPTH).
- `WAIT`, 2: load wait states inserted before the array read, range 0–15.

- `clk` input 1: single clock; everything is rising-edge.
- `rst` input 1: asynchronous, active-low reset.
- `req` input 1: MEM-stage access valid; held stable by the stalled pipeline until `ready`.
- `we` input 1: 1 means store, 0 means load; driven by MemWrite.
- `addr` input 32: word address, from the ALU result.
- `wdata` input 32: store data, from RD3.
- `rdata` output 32: load data, valid while `ready` is high in RESP.
- `ready` output 1: access complete this cycle.
- `err` output 1: sticky out-of-range flag (`addr >= DEPTH`); cleared only by reset.

## Operation
- Storage is a single-port synchronous array of DEPTH × 32 bits. In any cycle the port serves either one buffer drain or one load read, never both.
- FSM states:
  - IDLE, the accept state.
  - WAIT, which counts down wait states.
  - FETCH, the array read cycle.
  - RESP, which presents data.
- IDLE transitions:
  - `req & we`: store accepted. `ready`=1 combinationally in the same cycle. The buffer captures {addr, wdata} at the edge. The FSM stays in IDLE.
  - `req & ~we`: load launched. `addr` is latched and the wait counter is loaded with WAIT. Next state is WAIT if WAIT>0, otherwise FETCH.
  - `~req`: the FSM stays in IDLE and `ready`=0.
- WAIT: the counter decrements each cycle. When it reaches 1, the next state is FETCH.
- FETCH: the array is read at the latched address. Next state is RESP.
- RESP: `ready`=1 and `rdata` is driven from the capture register. Next state is IDLE.
- `req`, `we`, `addr` and `wdata` are ignored outside IDLE, because the pipeline is stalled and holds the request.
- Write buffer, one entry (valid, addr, data):
  - It drains into the array on every cycle where the buffer is valid and the state is not FETCH.
  - Capture and drain in the same cycle are allowed. The old entry writes the array and the new entry loads the buffer, so back-to-back stores run one per cycle with no stall.
  - A load is launched only from IDLE, so any buffered store drains during the launch cycle, before FETCH. Loads therefore always see prior stores, and no forwarding path is needed.
- Out-of-range handling (`addr >= DEPTH`):
  - Store: acknowledged normally, no array write, `err` set.
  - Load: normal latency, `rdata`=0 in RESP, `err` set.
  - For address decode, bits above AW are compared, not truncated.

## Timing
- Reset values:
  - state = IDLE
  - `ready` = 0
  - `rdata` = 0
  - `err` = 0
  - buffer valid = 0
  - wait counter = 0
- Reset mid-load returns to IDLE with no response.
- Reset with the buffer valid drops the pending store. The array contents are not reset.
- Store latency is 0 cycles: `ready` is asserted in the request cycle. The array is updated at the end of the following cycle, or later if that cycle is FETCH.
- Load latency: with the request first seen in cycle 0, `ready` is high in cycle WAIT+2. With WAIT=0, FETCH is cycle 1 and RESP is cycle 2.
- `rdata` holds its last value outside RESP. It is consumed only when `ready`=1.
- `ready` is high for exactly one cycle per load. After RESP, the next access is accepted in IDLE the following cycle.
- The `err` set is registered and becomes visible the cycle after acceptance (stores) or in RESP (loads).

## Test plan
- Reset with WAIT=2: `ready`=0, `rdata`=0, `err`=0. Load addr 5 issued at cycle 0 → `ready`=1 only in cycle 4, `rdata`=0 because the array was preloaded with 0.
- Store 0xDEADBEEF→addr 7, then load addr 7 in the next cycle → store `ready` in the same cycle; load returns 0xDEADBEEF, proving the drain happened before FETCH.
- Stores to addrs 1, 2, 3 on consecutive cycles, then loads of each → `ready`=1 in all three store cycles with no stall; loads return the written values.
- WAIT=0: load addr 3 → `ready` in cycle 2. WAIT=15: load addr 3 → `ready` in cycle 17.
- Store to addr DEPTH+4, then load addr DEPTH → store is acknowledged, `err`=1 the next cycle, and the array is unchanged; the load returns 0 with normal latency and `err` stays 1.
- `rst` asserted during a WAIT cycle of a load, and separately in the cycle after a store → FSM in IDLE, no `ready` pulse; in the second case a later load of the store address returns its old value.

Source files
------------

// File: rtl/data_mem_responder.sv
// Responder for the MEM-stage data-memory port: single-cycle stores through a one-entry
// write buffer, loads with WAIT wait states ahead of a synchronous array read.
module data_mem_responder #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = 10,
   parameter int unsigned WAIT  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err
);

   typedef enum logic [1:0] {StIdle, StWait, StFetch, StResp} state_e;

   localparam logic [3:0] WaitCnt = 4'(WAIT);

   state_e         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [AW-1:0]  ld_idx_q, ld_idx_d;
   logic           ld_oor_q, ld_oor_d;
   logic           buf_valid_q, buf_valid_d;
   logic [AW-1:0]  buf_addr_q, buf_addr_d;
   logic [31:0]    buf_data_q, buf_data_d;
   logic           err_q, err_d;
   logic [31:0]    rdata_q;
   logic           drain;
   logic           req_oor;

   logic [31:0]    mem [DEPTH];

   // Full-width compare so aliases above AW are flagged instead of wrapping.
   assign req_oor = (addr >= DEPTH);

   // The single array port is owned by the load read during FETCH.
   assign drain = buf_valid_q && (state_q != StFetch);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ld_idx_d    = ld_idx_q;
      ld_oor_d    = ld_oor_q;
      buf_valid_d = buf_valid_q;
      buf_addr_d  = buf_addr_q;
      buf_data_d  = buf_data_q;
      err_d       = err_q;
      ready       = 1'b0;

      if (drain) begin
         buf_valid_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (req) begin
               if (we) begin
                  ready = 1'b1;
                  if (req_oor) begin
                     err_d = 1'b1;
                  end else begin
                     buf_valid_d = 1'b1;
                     buf_addr_d  = addr[AW-1:0];
                     buf_data_d  = wdata;
                  end
               end else begin
                  ld_idx_d = addr[AW-1:0];
                  ld_oor_d = req_oor;
                  cnt_d    = WaitCnt;
                  state_d  = (WaitCnt == 4'd0) ? StFetch : StWait;
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = StFetch;
            end
         end
         StFetch: begin
            if (ld_oor_q) begin
               err_d = 1'b1;
            end
            state_d = StResp;
         end
         StResp: begin
            ready   = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         cnt_q       <= 4'd0;
         ld_idx_q    <= '0;
         ld_oor_q    <= 1'b0;
         buf_valid_q <= 1'b0;
         buf_addr_q  <= '0;
         buf_data_q  <= '0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ld_idx_q    <= ld_idx_d;
         ld_oor_q    <= ld_oor_d;
         buf_valid_q <= buf_valid_d;
         buf_addr_q  <= buf_addr_d;
         buf_data_q  <= buf_data_d;
         err_q       <= err_d;
         if (state_q == StFetch) begin
            rdata_q <= ld_oor_q ? 32'd0 : mem[ld_idx_q];
         end
      end
   end

   // Array contents survive reset; only the pending buffer entry is dropped.
   always_ff @(posedge clk) begin
      if (drain) begin
         mem[buf_addr_q] <= buf_data_q;
      end
   end

   assign rdata = rdata_q;
   assign err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: vector table, hand-written reset/error/latency
// sequences and randomized traffic against a flat memory model.
module tb_data_mem_responder;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned AW    = 10;
   localparam int          LAT2  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;

   logic [31:0] rdata2, rdata0, rdata15;
   logic        ready2, ready0, ready15;
   logic        err2, err0, err15;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH(DEPTH), .AW(AW), .WAIT(2)) u_w2 (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata2), .ready(ready2), .err(err2)
   );
   data_mem_responder #(.DEPTH(DEPTH), .AW(AW), .WAIT(0)) u_w0 (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata0), .ready(ready0), .err(err0)
   );
   data_mem_responder #(.DEPTH(DEPTH), .AW(AW), .WAIT(15)) u_w15 (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata15), .ready(ready15), .err(err15)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: a 64-word window of the array plus the sticky error flag.
   logic [31:0] model_mem [64];
   logic        model_err;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t tbl [10];

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chkint(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      next_cycle();
      rst = 1'b1;
      next_cycle();
   endtask

   task automatic do_idle(input string name, input logic exp_err);
      req = 1'b0;
      @(negedge clk);
      chk1({name, ".ready"}, ready2, 1'b0);
      chk1({name, ".err"}, err2, exp_err);
      next_cycle();
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic exp_err,
                           input string name);
      req   = 1'b1;
      we    = 1'b1;
      addr  = a;
      wdata = d;
      @(negedge clk);
      chk1({name, ".ready"}, ready2, 1'b1);
      chk1({name, ".err"}, err2, exp_err);
      next_cycle();
      req = 1'b0;
   endtask

   task automatic do_load(input logic [31:0] a, input logic [31:0] exp_data, input logic exp_err,
                          input string name);
      int cyc;
      req  = 1'b1;
      we   = 1'b0;
      addr = a;
      cyc  = 0;
      @(negedge clk);
      while (ready2 !== 1'b1 && cyc < 40) begin
         next_cycle();
         cyc++;
         @(negedge clk);
      end
      chkint({name, ".latency"}, cyc, LAT2);
      chk32({name, ".rdata"}, rdata2, exp_data);
      chk1({name, ".err"}, err2, exp_err);
      next_cycle();
      req = 1'b0;
   endtask

   int          f0, f2, f15;
   int          kind;
   int          r;
   logic [31:0] a;
   logic [31:0] d;
   logic [31:0] exp_d;
   logic        oor;

   initial begin
      // Stores are table-checked against literals; loads against the literal expectations.
      tbl[0] = '{1'b1, 32'd7, 32'hDEAD_BEEF, 32'd0, 1'b0};
      tbl[1] = '{1'b0, 32'd7, 32'd0, 32'hDEAD_BEEF, 1'b0};
      tbl[2] = '{1'b1, 32'd1, 32'h1111_1111, 32'd0, 1'b0};
      tbl[3] = '{1'b1, 32'd2, 32'h2222_2222, 32'd0, 1'b0};
      tbl[4] = '{1'b1, 32'd3, 32'h3333_3333, 32'd0, 1'b0};
      tbl[5] = '{1'b0, 32'd1, 32'd0, 32'h1111_1111, 1'b0};
      tbl[6] = '{1'b0, 32'd2, 32'd0, 32'h2222_2222, 1'b0};
      tbl[7] = '{1'b0, 32'd3, 32'd0, 32'h3333_3333, 1'b0};
      tbl[8] = '{1'b1, 32'd3, 32'hA5A5_A5A5, 32'd0, 1'b0};
      tbl[9] = '{1'b0, 32'd3, 32'd0, 32'hA5A5_A5A5, 1'b0};

      #2 rst = 1'b0;
      @(negedge clk);
      chk1("reset.ready", ready2, 1'b0);
      chk32("reset.rdata", rdata2, 32'd0);
      chk1("reset.err", err2, 1'b0);
      chk1("reset.err_w0", err0, 1'b0);
      chk1("reset.ready_w15", ready15, 1'b0);
      next_cycle();
      rst = 1'b1;
      next_cycle();

      model_err = 1'b0;
      for (int i = 0; i < 64; i++) begin
         do_store(32'(i), 32'd0, 1'b0, "clear");
         model_mem[i] = 32'd0;
      end
      do_idle("clear_drain", 1'b0);

      do_reset();
      do_load(32'd5, 32'd0, 1'b0, "first_load");
      do_idle("after_resp", 1'b0);

      for (int i = 0; i < 10; i++) begin
         if (tbl[i].we) begin
            do_store(tbl[i].addr, tbl[i].wdata, tbl[i].exp_err, $sformatf("tbl%0d", i));
            model_mem[tbl[i].addr[5:0]] = tbl[i].wdata;
         end else begin
            do_load(tbl[i].addr, tbl[i].exp_rdata, tbl[i].exp_err, $sformatf("tbl%0d", i));
         end
      end

      // Out-of-range store must not alias onto word 4; load of DEPTH reads zero.
      do_store(DEPTH + 32'd4, 32'hCAFE_F00D, 1'b0, "oor_store");
      do_idle("oor_err_next", 1'b1);
      do_load(DEPTH, 32'd0, 1'b1, "oor_load");
      do_load(32'd4, model_mem[4], 1'b1, "oor_no_alias");
      do_load(32'hFFFF_FC07, 32'd0, 1'b1, "oor_high_bits");

      // Reset during a WAIT cycle of a load.
      do_reset();
      req  = 1'b1;
      we   = 1'b0;
      addr = 32'd9;
      next_cycle();
      rst = 1'b0;
      req = 1'b0;
      @(negedge clk);
      chk1("rst_mid_load.ready", ready2, 1'b0);
      next_cycle();
      rst = 1'b1;
      for (int i = 0; i < 5; i++) do_idle("rst_mid_load.quiet", 1'b0);
      chk32("rst_mid_load.rdata", rdata2, 32'd0);
      do_store(32'd9, 32'h0909_0909, 1'b0, "rst_mid_load.accept");
      model_mem[9] = 32'h0909_0909;
      do_load(32'd9, 32'h0909_0909, 1'b0, "rst_mid_load.reload");

      // Reset in the cycle after a store drops the buffered write.
      req   = 1'b1;
      we    = 1'b1;
      addr  = 32'd20;
      wdata = 32'hAAAA_5555;
      @(negedge clk);
      chk1("rst_drop.ready", ready2, 1'b1);
      next_cycle();
      rst = 1'b0;
      req = 1'b0;
      @(negedge clk);
      next_cycle();
      rst = 1'b1;
      do_idle("rst_drop.idle", 1'b0);
      do_load(32'd20, model_mem[20], 1'b0, "rst_drop.old_value");

      // First-ready cycle for each WAIT setting with the load held from cycle 0.
      do_reset();
      f0  = -1;
      f2  = -1;
      f15 = -1;
      req  = 1'b1;
      we   = 1'b0;
      addr = 32'd3;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (ready0 === 1'b1 && f0 < 0) f0 = c;
         if (ready2 === 1'b1 && f2 < 0) f2 = c;
         if (ready15 === 1'b1 && f15 < 0) f15 = c;
         next_cycle();
      end
      req = 1'b0;
      chkint("latency.wait0", f0, 2);
      chkint("latency.wait2", f2, 4);
      chkint("latency.wait15", f15, 17);
      do_reset();
      model_err = 1'b0;

      for (int i = 0; i < 300; i++) begin
         kind = $urandom_range(0, 9);
         r    = $urandom_range(0, 19);
         if (r == 0) a = DEPTH + $urandom_range(0, 3000);
         else if (r == 1) a = $urandom | 32'h8000_0000;
         else a = $urandom_range(0, 63);
         d   = $urandom;
         oor = (a >= DEPTH);
         if (kind < 4) begin
            do_store(a, d, model_err, "rnd_store");
            if (oor) model_err = 1'b1;
            else model_mem[a[5:0]] = d;
         end else if (kind < 8) begin
            if (oor) model_err = 1'b1;
            exp_d = oor ? 32'd0 : model_mem[a[5:0]];
            do_load(a, exp_d, model_err, "rnd_load");
         end else begin
            do_idle("rnd_idle", model_err);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
